// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, one-entry skid buffer,
// flush and bubble word. Optional statistics counters under PIPE_STAGE_STATS_EN.
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | no valid entry, out_data = BUBBLE
// FULL  | main entry valid, skid entry empty
// SKID  | main and skid entries valid, in_ready = 0
module pipe_stage_reg #(
  parameter int               WIDTH  = 179,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
`ifdef PIPE_STAGE_STATS_EN
  , parameter int             CNT_W  = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush
`ifdef PIPE_STAGE_STATS_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             main_v;
  logic             skid_v;
  logic             accept;
  logic             consume;

  assign main_v    = (state != EMPTY);
  assign skid_v    = (state == SKID);
  assign in_ready  = (state != SKID);
  assign out_valid = main_v;
  assign out_data  = main_v ? main_q : BUBBLE;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  // Flush only clears the valid state; payload registers keep their contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= {WIDTH{1'b0}};
      skid_q <= {WIDTH{1'b0}};
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_data;
            state  <= FULL;
          end
        end
        FULL: begin
          case ({consume, accept})
            2'b10: state <= EMPTY;
            2'b11: main_q <= in_data;
            2'b01: begin
              skid_q <= in_data;
              state  <= SKID;
            end
            default: state <= FULL;
          endcase
        end
        SKID: begin
          if (consume) begin
            main_q <= skid_q;
            state  <= FULL;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  // Saturating counters: hold at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush && (main_v || skid_v) && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the 5-stage pipeline; it generalises the fixed-width IF/ID, ID/EX, EX/MEM and MEM/WB registers. It adds a valid/ready handshake with a one-entry skid buffer, so back-pressure does not need a combinational stall path across the whole pipe. It also adds a flush that kills in-flight entries, and a programmable bubble word driven whenever no valid entry is held. One instance sits between each pair of adjacent stages.

Parameters:
WIDTH, 179, payload bits per entry (MEM/WB layout width).
BUBBLE, {WIDTH{1'b0}}, value driven on out_data when out_valid=0; control bits such as RegWrite, MemToReg, FPRegWrite and trap must decode as no-op.
CNT_W, 32, width of the statistics counters (used only with PIPE_STAGE_STATS_EN).

Ports:
clk  in  1  pipeline clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  upstream stage presents an entry.
in_ready  out  1  register can accept an entry this cycle.
in_data  in  WIDTH  upstream payload.
out_valid  out  1  entry held for the downstream stage.
out_ready  in  1  downstream stage consumes the entry this cycle.
out_data  out  WIDTH  payload of the main entry, or BUBBLE when out_valid=0.
flush  in  1  kill all held entries (branch mispredict or trap).
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0 (macro only).
flush_cnt  out  CNT_W  flush cycles that killed at least one valid entry (macro only).

Behaviour:
- Storage: main entry (main_q, main_v) and skid entry (skid_q, skid_v). All are registered; out_data and out_valid come from the main entry only.
- States: EMPTY (main_v=0, skid_v=0), FULL (main_v=1, skid_v=0), SKID (main_v=1, skid_v=1).
- in_ready = (state != SKID). This is a registered-state decode and has no combinational path from out_ready.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Transitions, evaluated when flush=0:
  - EMPTY: accept -> main<=in_data, go to FULL.
  - FULL, consume without accept -> EMPTY.
  - FULL, consume with accept -> main<=in_data, stay in FULL.
  - FULL, accept without consume -> skid<=in_data, go to SKID.
  - FULL, neither -> hold.
  - SKID: consume -> main<=skid, skid_v<=0, go to FULL. No accept is possible because in_ready=0.
  - SKID, no consume -> hold.
- Latency: an entry accepted in cycle N appears on out_data/out_valid in cycle N+1. Throughput is 1 entry/cycle while out_ready=1.
- Ordering is strictly FIFO. The skid entry is never bypassed.
- Flush dominates everything. It clears main_v and skid_v at the next edge, and state goes to EMPTY. An entry presented with in_valid in the flush cycle is dropped, even though in_ready may read 1. A consume in the flush cycle still counts as a downstream transfer.
- Data registers load only on accept or skid-to-main moves. Payload is not cleared on flush; only the valid bits are cleared.
- out_data = main_v ? main_q : BUBBLE. This holds during reset too.
- Reset (asynchronous, reset=1): main_v=0, skid_v=0, state EMPTY, out_valid=0, out_data=BUBBLE, in_ready=1, counters=0. Reset asserted mid-transfer discards both entries, and no partial load occurs.
- Width rule: the payload is passed through bit-exact. The register does not interpret fields.

Optional Feature:
PIPE_STAGE_STATS_EN
- Defined: stall_cnt and flush_cnt ports exist. Each is a CNT_W-bit counter that saturates at all-ones and never wraps.
  - stall_cnt increments in each cycle with out_valid & !out_ready & !flush.
  - flush_cnt increments in each cycle with flush & (main_v | skid_v).
  - Both reset to 0 asynchronously.
- Undefined: both ports and their counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert reset mid-cycle with in_valid=1 and in_data=0x5A repeated -> out_valid=0, out_data=BUBBLE and in_ready=1 immediately (asynchronous), with no clock edge needed.
- Streaming: out_ready=1, present payloads 1,2,3,4 on consecutive cycles -> out_data shows 1,2,3,4 one cycle later, and out_valid=1 for 4 cycles.
- Back-pressure:
  - Send A, then B. Drop out_ready after A reaches output -> state SKID, in_ready=0 on the cycle after B.
  - Raise out_ready -> A then B delivered in order, and in_ready returns to 1 after B moves into main.
- Flush in SKID: flush=1 with in_valid=1 and in_data=C -> next cycle out_valid=0, out_data=BUBBLE, in_ready=1, and C never appears at the output.
- Simultaneous consume and accept in FULL: out_ready=1, in_valid=1 carrying D while E is held -> E transferred, then out_data=D next cycle, with no bubble in between.
- Stats (macro defined): hold out_ready=0 for 7 cycles with a valid entry, then flush once -> stall_cnt=7 and flush_cnt=1. With CNT_W=4 and 20 stall cycles -> stall_cnt saturates at 15.
